// File: rtl/timer_pkg.sv
// Shared types and default moduli for the up-counting hours/minutes/seconds timer.
// Contents:
//   DW_D       default time-field width
//   field_t    one time field at the default width
//   *_MOD_D    default moduli for seconds, minutes and hours
package timer_pkg;

    localparam int DW_D      = 8;
    localparam int SEC_MOD_D = 60;
    localparam int MIN_MOD_D = 60;
    localparam int HRS_MOD_D = 24;

    typedef logic [DW_D-1:0] field_t;

endpackage

// File: rtl/counter_up_mod.sv
// One modulo-MOD up-counting field with synchronous load.
// Ports:
//   clk     system clock
//   rst     asynchronous active-high reset, clears q
//   inc     advance q by one this edge (wraps MOD-1 -> 0)
//   ld      load ld_val this edge (has priority over inc)
//   ld_val  load value; values >= MOD load 0
//   q       current count, registered, always within 0..MOD-1
//   tc      combinational carry out: inc while q == MOD-1
module counter_up_mod #(
    parameter int dw  = 8,
    parameter int MOD = 60
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          ld,
    input  logic [dw-1:0] ld_val,
    output logic [dw-1:0] q,
    output logic          tc
);

    localparam logic [dw-1:0] LAST = dw'(MOD - 1);
    localparam logic [dw-1:0] LIM  = dw'(MOD);

    logic at_last;

    // Terminal compare instead of overflow detection keeps q inside 0..MOD-1.
    assign at_last = (q == LAST);
    assign tc      = inc & at_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (ld) begin
            q <= (ld_val >= LIM) ? '0 : ld_val;
        end else if (inc) begin
            q <= at_last ? '0 : q + dw'(1);
        end
    end

endmodule

// File: rtl/timer_up_hms.sv
// Elapsed-time keeper: seconds -> minutes -> hours, each a modulo field with
// ripple carry resolved in a single edge. Driven by a 1 Hz ena tick.
// Optional feature: define TIMER_UP_ALARM_EN to enable the hour/minute alarm;
// otherwise alarm is tied low and the alm_* inputs are ignored.
// Ports:
//   clk, reset                    clock; asynchronous active-high reset
//   ena                           advance seconds by one
//   set_min, set_hrs              bump minutes/hours by one, no carry out
//   ld, ld_sec, ld_min, ld_hrs    synchronous load of all three fields
//   alm_arm, alm_min, alm_hrs     alarm arm and match time
//   sec, min, hrs                 registered time fields
//   day_wrap                      one-cycle pulse after 23:59:59 -> 00:00:00
//   alarm                         registered alarm match
module timer_up_hms
    import timer_pkg::*;
#(
    parameter int dw      = DW_D,
    parameter int SEC_MOD = SEC_MOD_D,
    parameter int MIN_MOD = MIN_MOD_D,
    parameter int HRS_MOD = HRS_MOD_D
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ena,
    input  logic          set_min,
    input  logic          set_hrs,
    input  logic          ld,
    input  logic [dw-1:0] ld_sec,
    input  logic [dw-1:0] ld_min,
    input  logic [dw-1:0] ld_hrs,
    input  logic          alm_arm,
    input  logic [dw-1:0] alm_min,
    input  logic [dw-1:0] alm_hrs,
    output logic [dw-1:0] sec,
    output logic [dw-1:0] min,
    output logic [dw-1:0] hrs,
    output logic          day_wrap,
    output logic          alarm
);

    logic set_any;
    logic sec_inc, min_inc, hrs_inc;
    logic sec_tc, min_tc, hrs_tc;
    logic wrap_c;

    assign set_any = set_min | set_hrs;

    // Priority ld > set > ena is applied to the increments so that carries
    // never leak out of a set or load edge.
    assign sec_inc = ena & ~set_any & ~ld;
    assign min_inc = ~ld & (set_any ? set_min : sec_tc);
    assign hrs_inc = ~ld & (set_any ? set_hrs : min_tc);
    assign wrap_c  = hrs_tc & ~set_any;

    counter_up_mod #(.dw(dw), .MOD(SEC_MOD)) u_sec (
        .clk    (clk),
        .rst    (reset),
        .inc    (sec_inc),
        .ld     (ld),
        .ld_val (ld_sec),
        .q      (sec),
        .tc     (sec_tc)
    );

    counter_up_mod #(.dw(dw), .MOD(MIN_MOD)) u_min (
        .clk    (clk),
        .rst    (reset),
        .inc    (min_inc),
        .ld     (ld),
        .ld_val (ld_min),
        .q      (min),
        .tc     (min_tc)
    );

    counter_up_mod #(.dw(dw), .MOD(HRS_MOD)) u_hrs (
        .clk    (clk),
        .rst    (reset),
        .inc    (hrs_inc),
        .ld     (ld),
        .ld_val (ld_hrs),
        .q      (hrs),
        .tc     (hrs_tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            day_wrap <= 1'b0;
        end else begin
            day_wrap <= wrap_c;
        end
    end

`ifdef TIMER_UP_ALARM_EN
    // Compares the registered fields, so alarm follows the displayed time by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alarm <= 1'b0;
        end else begin
            alarm <= alm_arm & (min == alm_min) & (hrs == alm_hrs);
        end
    end
`else
    logic unused_alm;

    assign unused_alm = ^{alm_arm, alm_min, alm_hrs};
    assign alarm      = 1'b0;
`endif

endmodule
